// File: rtl/alu_pkg.sv
// Shared ALU control codes, execute-stage FSM states and decode helpers.
package alu_pkg;

    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSlt  = 4'b0111;
    localparam logic [3:0] AluXor  = 4'b1000;
    localparam logic [3:0] AluSll  = 4'b1001;
    localparam logic [3:0] AluSrl  = 4'b1010;
    localparam logic [3:0] AluSra  = 4'b1011;
    localparam logic [3:0] AluSltu = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    function automatic logic is_shift(input logic [3:0] ctl);
        return (ctl == AluSll) || (ctl == AluSrl) || (ctl == AluSra);
    endfunction

endpackage

// File: rtl/alu_exec_unit_logic.sv
// Single-cycle ALU ops plus illegal-code detection; shift codes yield zero here.
module alu_logic
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       ctl_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    logic slt;
    logic sltu;

    assign slt  = $signed(op_a_i) < $signed(op_b_i);
    assign sltu = op_a_i < op_b_i;

    // Decode the control code; anything undefined flags illegal with a zero result.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (ctl_i)
            AluAnd:  result_o = op_a_i & op_b_i;
            AluOr:   result_o = op_a_i | op_b_i;
            AluAdd:  result_o = op_a_i + op_b_i;
            AluSub:  result_o = op_a_i - op_b_i;
            AluSlt:  result_o = {{(WIDTH-1){1'b0}}, slt};
            AluXor:  result_o = op_a_i ^ op_b_i;
            AluSltu: result_o = {{(WIDTH-1){1'b0}}, sltu};
            AluSll, AluSrl, AluSra: result_o = '0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: one-cycle logic/arith, bit-serial shifts.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [SHW-1:0] CountOne = SHW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [3:0]       kind_q, kind_d;

    logic [WIDTH-1:0] logic_result;
    logic             logic_illegal;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   shamt;

    assign shamt = op_b[SHW-1:0];

    alu_logic #(
        .WIDTH (WIDTH)
    ) u_alu_logic (
        .ctl_i     (alu_ctl),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .result_o  (logic_result),
        .illegal_o (logic_illegal)
    );

    // One-bit step of the working register; result_q doubles as the shift register.
    always_comb begin
        shifted = {1'b0, result_q[WIDTH-1:1]};
        case (kind_q)
            AluSll:  shifted = {result_q[WIDTH-2:0], 1'b0};
            AluSra:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shifted = {1'b0, result_q[WIDTH-1:1]};
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        kind_d    = kind_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_shift(alu_ctl)) begin
                        result_d  = op_a;
                        zero_d    = (op_a == '0);
                        illegal_d = 1'b0;
                        if (shamt == '0) begin
                            state_d = StHold;
                        end else begin
                            count_d = shamt;
                            kind_d  = alu_ctl;
                            state_d = StShift;
                        end
                    end else begin
                        result_d  = logic_result;
                        zero_d    = (logic_result == '0);
                        illegal_d = logic_illegal;
                        state_d   = StHold;
                    end
                end
            end
            StShift: begin
                result_d = shifted;
                zero_d   = (shifted == '0);
                count_d  = count_q - CountOne;
                if (count_q == CountOne) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            count_q   <= '0;
            kind_q    <= AluSll;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
            kind_q    <= kind_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit against a behavioural ALU model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_ctl = 4'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int shamt_of(input logic [W-1:0] b);
        return int'(b % W);
    endfunction

    function automatic logic is_shift_code(input logic [3:0] c);
        return c == 4'd9 || c == 4'd10 || c == 4'd11;
    endfunction

    function automatic logic model_ill(input logic [3:0] c);
        case (c)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [W-1:0] model_res(input logic [3:0] c, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int sh;
        sh = shamt_of(b);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd8:  return a ^ b;
            4'd9:  return a << sh;
            4'd10: return a >> sh;
            4'd11: return $signed(a) >>> sh;
            4'd12: return (a < b) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [W-1:0] b);
        return is_shift_code(c) ? 1 + shamt_of(b) : 1;
    endfunction

    // Drive one op from IDLE with out_ready high; returns observed outputs and latency.
    // Caller is positioned 1 time unit after a rising edge.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic z, output logic il,
                          output int lat);
        in_valid  = 1'b1;
        alu_ctl   = c;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctl  = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < W + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        r  = result;
        z  = zero;
        il = illegal;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 ||
            illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b res=%h z=%b il=%b required 1 0 0 1 0",
                     in_ready, out_valid, result, zero, illegal);
        end
    endtask

    task automatic test_directed;
        logic [3:0]   c [9]  = '{4'd2, 4'd6, 4'd6, 4'd7, 4'd12, 4'd9, 4'd10, 4'd15, 4'd10};
        logic [W-1:0] a [9]  = '{32'd5, 32'd3, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                                 32'hFFFFFFFF, 32'h1234, 32'h80};
        logic [W-1:0] b [9]  = '{32'd7, 32'd5, 32'd9, 32'd1, 32'd1, 32'd0, 32'd31, 32'h55,
                                 32'd33};
        logic [W-1:0] er [9] = '{32'd12, 32'hFFFFFFFE, 32'd0, 32'd1, 32'd0, 32'h1, 32'h1, 32'd0,
                                 32'h40};
        logic         ez [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         ei [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int           el [9] = '{1, 1, 1, 1, 1, 1, 32, 1, 2};
        logic [W-1:0] r;
        logic         z, il;
        int           lat;
        for (int i = 0; i < 9; i++) begin
            run_op(c[i], a[i], b[i], r, z, il, lat);
            n_vec++;
            if (r !== er[i] || z !== ez[i] || il !== ei[i] || lat !== el[i]) begin
                n_err++;
                $display("FAIL directed[%0d] ctl=%b: res=%h z=%b il=%b lat=%0d required %h %b %b %0d",
                         i, c[i], r, z, il, lat, er[i], ez[i], ei[i], el[i]);
            end
        end
    endtask

    task automatic test_sra_timing;
        int low_cnt = 0;
        in_valid  = 1'b1;
        alu_ctl   = 4'b1011;
        op_a      = 32'h80000000;
        op_b      = 32'd4;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready === 1'b0 && out_valid === 1'b0) low_cnt++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (low_cnt != 4 || out_valid !== 1'b1 || result !== 32'hF8000000) begin
            n_err++;
            $display("FAIL sra_timing: busy_cycles=%0d vld=%b res=%h required 4 1 f8000000",
                     low_cnt, out_valid, result);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a, b, exp;
        a = $urandom;
        b = $urandom;
        exp = a + b;
        in_valid  = 1'b1;
        alu_ctl   = 4'b0010;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            alu_ctl  = 4'b0110;
            op_a     = $urandom;
            op_b     = $urandom;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
                n_err++;
                $display("FAIL backpressure[%0d]: vld=%b rdy=%b res=%h required 1 0 %h",
                         i, out_valid, in_ready, result, exp);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        in_valid  = 1'b1;
        alu_ctl   = 4'b0000;
        op_a      = $urandom;
        op_b      = $urandom;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready === 1'b1) accepts++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (accepts != 5) begin
            n_err++;
            $display("FAIL back_to_back: accepts=%0d required 5", accepts);
        end
    endtask

    task automatic test_random;
        logic [3:0]   c;
        logic [W-1:0] a, b, r;
        logic         z, il;
        int           lat;
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'h80000000 | W'($urandom_range(0, 15));
            run_op(c, a, b, r, z, il, lat);
            n_vec++;
            if (r !== model_res(c, a, b) || z !== (model_res(c, a, b) == '0) ||
                il !== model_ill(c) || lat !== model_lat(c, b)) begin
                n_err++;
                $display("FAIL random[%0d] ctl=%b a=%h b=%h: res=%h z=%b il=%b lat=%0d required %h %b %b %0d",
                         i, c, a, b, r, z, il, lat, model_res(c, a, b),
                         model_res(c, a, b) == '0, model_ill(c), model_lat(c, b));
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [W-1:0] r;
        logic         z, il;
        int           lat;
        int           vld_seen = 0;
        in_valid  = 1'b1;
        alu_ctl   = 4'b1001;
        op_a      = 32'hA5A5_0003;
        op_b      = 32'd20;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 ||
            illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_shift: rdy=%b vld=%b res=%h z=%b il=%b required 1 0 0 1 0",
                     in_ready, out_valid, result, zero, illegal);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) begin
            if (out_valid !== 1'b0) vld_seen++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (vld_seen != 0) begin
            n_err++;
            $display("FAIL reset_no_valid: valid_cycles=%0d required 0", vld_seen);
        end
        run_op(4'b0010, 32'd1, 32'd1, r, z, il, lat);
        n_vec++;
        if (r !== 32'd2 || z !== 1'b0 || il !== 1'b0 || lat !== 1) begin
            n_err++;
            $display("FAIL add_after_reset: res=%h z=%b il=%b lat=%0d required 2 0 0 1",
                     r, z, il, lat);
        end
    endtask

    initial begin
        #12;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed;
        test_sra_timing;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid_shift;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
